// File: rtl/fault_retry_ctrl_pkg.sv
// fault_retry_ctrl_pkg: state encoding, default cycle constants and sizing helper
// shared by the fault auto-restart supervisor and its timer sub-module.
package fault_retry_ctrl_pkg;

  // One-hot supervisor states
  typedef enum logic [4:0] {
    ST_RUN    = 5'b00001,
    ST_COOL   = 5'b00010,
    ST_PULSE  = 5'b00100,
    ST_VERIFY = 5'b01000,
    ST_LOCK   = 5'b10000
  } state_t;

  // Default timing for a 50 MHz system clock
  localparam int unsigned DEF_COOLDOWN_CYC = 25_000_000;  // 500 ms
  localparam int unsigned DEF_PULSE_CYC    = 50;          // 1 us
  localparam int unsigned DEF_MAX_RETRY    = 3;
  localparam int unsigned DEF_STABLE_CYC   = 50_000_000;  // 1 s

  // Largest of three cycle counts, used to size the shared counters
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/fault_retry_ctrl_cyc_timer.sv
// cyc_timer: TW-bit up-counter with synchronous clear, count enable and a
// terminal-count compare against a run-time selectable terminal value.
module cyc_timer #(
  parameter int unsigned TW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic [TW-1:0] i_term,
  output logic          o_tc
);

  logic [TW-1:0] r_cnt;

  // Count up while enabled; clear has priority over counting
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + TW'(1);
    end
  end

  assign o_tc = (r_cnt == i_term);

endmodule

// File: rtl/fault_retry_ctrl.sv
// fault_retry_ctrl: auto-restart supervisor for the bus-protect latch.
// Watches PWMEN for trips, waits a cooldown, pulses ResetD to re-arm the latch,
// and locks out after MAX_RETRY consecutive trips until the DSP sends ManualClr.
// Optional feature macro: FAULT_TOTAL_EN (lifetime saturating trip counter on
// FaultTotal; when undefined FaultTotal is tied to zero).
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_RUN    | PWM running, watching for trips, stable-run timer active
// ST_COOL   | trip seen, waiting COOLDOWN_CYC before re-arming
// ST_PULSE  | ResetD high for PULSE_CYC cycles
// ST_VERIFY | one cycle: PWMEN back high -> RUN, else -> LOCK
// ST_LOCK   | permanent fault, waits for ManualClr
module fault_retry_ctrl
  import fault_retry_ctrl_pkg::*;
#(
  parameter int unsigned COOLDOWN_CYC = DEF_COOLDOWN_CYC,
  parameter int unsigned PULSE_CYC    = DEF_PULSE_CYC,
  parameter int unsigned MAX_RETRY    = DEF_MAX_RETRY,
  parameter int unsigned STABLE_CYC   = DEF_STABLE_CYC,
  localparam int unsigned RW          = $clog2(MAX_RETRY + 1)
) (
  input  logic          CLK_50M,
  input  logic          Rst_n,
  input  logic          PWMEN,
  input  logic          ManualClr,
  output logic          ResetD,
  output logic          Lockout,
  output logic          FaultAct,
  output logic [RW-1:0] RetryCnt,
  output logic [7:0]    FaultTotal
);

  localparam int unsigned TW = $clog2(max3(COOLDOWN_CYC, PULSE_CYC, STABLE_CYC) + 1);

  state_t        r_state;
  state_t        w_next;
  logic          r_pwmen_d;
  logic [RW-1:0] r_retry;
  logic          r_resetd;
  logic          r_lockout;
  logic          r_fault_act;

  logic          w_trip;
  logic          w_tmr_clr;
  logic          w_tmr_en;
  logic [TW-1:0] w_tmr_term;
  logic          w_tmr_tc;
  logic          w_stb_clr;
  logic          w_stb_en;
  logic          w_stb_tc;
  logic          w_stb_expire;

  assign w_trip = r_pwmen_d & ~PWMEN;

  // Shared state timer: restarts on every state change, only COOL/PULSE use it
  assign w_tmr_clr  = (w_next != r_state);
  assign w_tmr_en   = (r_state == ST_COOL) | (r_state == ST_PULSE);
  assign w_tmr_term = (r_state == ST_COOL) ? TW'(COOLDOWN_CYC - 1) : TW'(PULSE_CYC - 1);

  cyc_timer #(.TW(TW)) u_state_tmr (
    .i_clk   (CLK_50M),
    .i_rst_n (Rst_n),
    .i_clr   (w_tmr_clr),
    .i_en    (w_tmr_en),
    .i_term  (w_tmr_term),
    .o_tc    (w_tmr_tc)
  );

  // Stable-run counter: runs only through uninterrupted PWMEN=1 in RUN and
  // saturates at its terminal value instead of wrapping.
  assign w_stb_clr    = (r_state != ST_RUN) | w_trip | ~PWMEN;
  assign w_stb_en     = ~w_stb_tc;
  assign w_stb_expire = (r_state == ST_RUN) & ~w_trip & PWMEN & w_stb_tc;

  cyc_timer #(.TW(TW)) u_stable_tmr (
    .i_clk   (CLK_50M),
    .i_rst_n (Rst_n),
    .i_clr   (w_stb_clr),
    .i_en    (w_stb_en),
    .i_term  (TW'(STABLE_CYC - 1)),
    .o_tc    (w_stb_tc)
  );

  // Next-state decode; any non one-hot state recovers to RUN
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_trip) w_next = (r_retry == RW'(MAX_RETRY)) ? ST_LOCK : ST_COOL;
      end
      ST_COOL: begin
        if (w_tmr_tc) w_next = ST_PULSE;
      end
      ST_PULSE: begin
        if (w_tmr_tc) w_next = ST_VERIFY;
      end
      ST_VERIFY: begin
        w_next = PWMEN ? ST_RUN : ST_LOCK;
      end
      ST_LOCK: begin
        if (ManualClr) w_next = ST_PULSE;
      end
      default: w_next = ST_RUN;
    endcase
  end

  // State register, retry counter and outputs registered from the next state
  always_ff @(posedge CLK_50M or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state     <= ST_RUN;
      r_pwmen_d   <= 1'b1;
      r_retry     <= '0;
      r_resetd    <= 1'b0;
      r_lockout   <= 1'b0;
      r_fault_act <= 1'b0;
    end else begin
      r_pwmen_d   <= PWMEN;
      r_state     <= w_next;
      r_resetd    <= (w_next == ST_PULSE);
      r_lockout   <= (w_next == ST_LOCK);
      r_fault_act <= (w_next != ST_RUN);
      case (r_state)
        ST_RUN: begin
          // a trip beats a simultaneous stable-run expiry
          if (w_trip) begin
            if (r_retry != RW'(MAX_RETRY)) r_retry <= r_retry + RW'(1);
          end else if (w_stb_expire) begin
            r_retry <= '0;
          end
        end
        ST_LOCK: begin
          if (ManualClr) r_retry <= '0;
        end
        ST_COOL, ST_PULSE, ST_VERIFY: r_retry <= r_retry;
        default: r_retry <= '0;
      endcase
    end
  end

  assign ResetD   = r_resetd;
  assign Lockout  = r_lockout;
  assign FaultAct = r_fault_act;
  assign RetryCnt = r_retry;

`ifdef FAULT_TOTAL_EN
  logic [7:0] r_fault_total;
  logic       w_trip_acted;

  assign w_trip_acted = (r_state == ST_RUN) & w_trip;

  // Lifetime trip count, saturating, cleared only by reset
  always_ff @(posedge CLK_50M or negedge Rst_n) begin
    if (!Rst_n) begin
      r_fault_total <= 8'h00;
    end else if (w_trip_acted && (r_fault_total != 8'hFF)) begin
      r_fault_total <= r_fault_total + 8'd1;
    end
  end

  assign FaultTotal = r_fault_total;
`else
  assign FaultTotal = 8'h00;
`endif

endmodule
